// File: rtl/seqdiv_pkg.sv
// ============================================================================
// seqdiv_pkg : shared FSM state type and counter-width helper for seqdiv_fx
// Rev 1.0
// ============================================================================
`default_nettype none

package seqdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seqdiv_fx_if.sv
// ============================================================================
// seqdiv_fx_if : start/ready/done request and result bundle for seqdiv_fx
// Rev 1.0
// ============================================================================
`default_nettype none

interface seqdiv_fx_if #(
    parameter int DW = 19,
    parameter int QW = 8
) ();

    logic          start;
    logic [DW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          ready;
    logic          done;
    logic [QW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          overflow;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, overflow, div_by_zero
    );

endinterface

`default_nettype wire

// File: rtl/seqdiv_nr_step.sv
// ============================================================================
// seqdiv_nr_step : one radix-2 non-restoring division step (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module seqdiv_nr_step #(
    parameter int DW = 19
) (
    input  logic [DW:0] a_i,
    input  logic        q_msb_i,
    input  logic [DW:0] m_i,
    output logic [DW:0] a_o,
    output logic        q_bit_o
);

    logic [DW:0] shl;

    // The sign of the pre-shift accumulator picks add vs subtract;
    // intermediate wrap is harmless because the result lands in [-M, M).
    assign shl     = {a_i[DW-1:0], q_msb_i};
    assign a_o     = a_i[DW] ? (shl + m_i) : (shl - m_i);
    assign q_bit_o = ~a_o[DW];

endmodule

`default_nettype wire

// File: rtl/seqdiv_fx.sv
// ============================================================================
// seqdiv_fx : sequential fixed-point divider, (dividend << FRAC) / divisor
// Rev 1.0
// ============================================================================
`default_nettype none

module seqdiv_fx #(
    parameter int DW   = 19,
    parameter int FRAC = 8,
    parameter int QW   = 8
) (
    input  logic        clk,
    input  logic        RST,
    seqdiv_fx_if.slave  bus
);

    import seqdiv_pkg::*;

    localparam int N  = DW + FRAC;
    localparam int CW = cnt_width(N);

    state_t        state_q;
    logic [DW:0]   a_q;
    logic [N-1:0]  num_q;
    logic [DW-1:0] m_q;
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          done_q;
    logic [QW-1:0] quot_q;
    logic [DW-1:0] rem_q;
    logic          ovf_q;
    logic          dz_q;

    logic [DW:0]   a_d;
    logic          qbit_d;
    logic [DW-1:0] rem_d;
    logic          hi_nz;

    seqdiv_nr_step #(.DW(DW)) u_step (
        .a_i     (a_q),
        .q_msb_i (num_q[N-1]),
        .m_i     ({1'b0, m_q}),
        .a_o     (a_d),
        .q_bit_o (qbit_d)
    );

    assign rem_d = a_q[DW] ? (a_q[DW-1:0] + m_q) : a_q[DW-1:0];

    generate
        if (QW < N) begin : g_ovf
            assign hi_nz = |num_q[N-1:QW];
        end else begin : g_no_ovf
            assign hi_nz = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            num_q   <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= bus.divisor;
                        num_q   <= {bus.dividend, {FRAC{1'b0}}};
                        a_q     <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= (bus.divisor == '0) ? DONE : ITER;
                    end
                end
                ITER: begin
                    a_q   <= a_d;
                    num_q <= {num_q[N-2:0], qbit_d};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    a_q     <= a_q[DW] ? (a_q + {1'b0, m_q}) : a_q;
                    rem_q   <= rem_d;
                    quot_q  <= hi_nz ? '1 : num_q[QW-1:0];
                    ovf_q   <= hi_nz;
                    dz_q    <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    // Arriving without done set means the zero-divisor path:
                    // publish the saturated result this edge, exit on the next.
                    if (done_q) begin
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        quot_q <= '1;
                        rem_q  <= '0;
                        ovf_q  <= 1'b1;
                        dz_q   <= 1'b1;
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready       = ready_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dz_q;

endmodule

`default_nettype wire
